// File: rtl/alu_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_arbiter_if
//  Description : Bundle of the two requester channels, the two response
//                channels and the shared-ALU port used by alu_arbiter.
//                The slave modport is the arbiter's view. The master modport
//                is the view of the requesters and the ALU.
//  Revision    : 1.0 - initial release
// ============================================================================
interface alu_arbiter_if #(
    parameter int DATA_WIDTH = 32
);
    // Requester side
    logic                  req0_valid_i;
    logic                  req1_valid_i;
    logic                  req0_ready_o;
    logic                  req1_ready_o;
    logic [3:0]            req0_op_i;
    logic [3:0]            req1_op_i;
    logic [DATA_WIDTH-1:0] req0_a_i;
    logic [DATA_WIDTH-1:0] req0_b_i;
    logic [DATA_WIDTH-1:0] req1_a_i;
    logic [DATA_WIDTH-1:0] req1_b_i;

    // Shared ALU side
    logic [3:0]            alu_operation_o;
    logic [DATA_WIDTH-1:0] alu_a_o;
    logic [DATA_WIDTH-1:0] alu_b_o;
    logic [DATA_WIDTH-1:0] alu_result_i;

    // Response side
    logic                  rsp0_valid_o;
    logic                  rsp1_valid_o;
    logic                  rsp0_ready_i;
    logic                  rsp1_ready_i;
    logic [DATA_WIDTH-1:0] rsp_data_o;

    modport slave (
        input  req0_valid_i, req1_valid_i,
        input  req0_op_i, req1_op_i,
        input  req0_a_i, req0_b_i, req1_a_i, req1_b_i,
        output req0_ready_o, req1_ready_o,
        output alu_operation_o, alu_a_o, alu_b_o,
        input  alu_result_i,
        output rsp0_valid_o, rsp1_valid_o,
        input  rsp0_ready_i, rsp1_ready_i,
        output rsp_data_o
    );

    modport master (
        output req0_valid_i, req1_valid_i,
        output req0_op_i, req1_op_i,
        output req0_a_i, req0_b_i, req1_a_i, req1_b_i,
        input  req0_ready_o, req1_ready_o,
        input  alu_operation_o, alu_a_o, alu_b_o,
        output alu_result_i,
        input  rsp0_valid_o, rsp1_valid_o,
        output rsp0_ready_i, rsp1_ready_i,
        input  rsp_data_o
    );
endinterface
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : alu_arbiter
//  Description : Shares one combinational ALU between two requesters.
//                Each accepted operation takes three phases: it is accepted
//                in IDLE, issued to the ALU in EXEC, and its result is held
//                in RESP until the owning requester consumes it.
//                Two requests that arrive together are resolved round-robin.
//                Define ALU_ARBITER_FIXED_PRIO_EN to make req0 always win a
//                tie instead.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_arbiter #(
    parameter int DATA_WIDTH = 32
) (
    input  wire           clk,
    input  wire           reset,     // asynchronous, active-low
    alu_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_next_state;

    logic                  r_gnt;        // owner of the in-flight operation
    logic [3:0]            r_op;
    logic [DATA_WIDTH-1:0] r_a;
    logic [DATA_WIDTH-1:0] r_b;
    logic [DATA_WIDTH-1:0] r_result;

    logic                  w_any_valid;
    logic                  w_gnt_id;
    logic                  w_accept;
    logic                  w_req0_ready;
    logic                  w_req1_ready;
    logic                  w_rsp0_valid;
    logic                  w_rsp1_valid;

    assign w_any_valid = bus.req0_valid_i | bus.req1_valid_i;

`ifdef ALU_ARBITER_FIXED_PRIO_EN
    // Fixed priority: req0 wins whenever it is valid.
    always_comb begin
        w_gnt_id = ~bus.req0_valid_i;
    end
`else
    // Round-robin pointer. It resets to 1 so that req0 wins the first tie.
    logic r_last_grant;

    // Choose the winner: on a tie, grant the requester that was not granted last.
    always_comb begin
        if (bus.req0_valid_i && bus.req1_valid_i) begin
            w_gnt_id = ~r_last_grant;
        end else begin
            w_gnt_id = ~bus.req0_valid_i;
        end
    end

    // Update the pointer on every acceptance.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_last_grant <= 1'b1;
        end else if (w_accept) begin
            r_last_grant <= w_gnt_id;
        end
    end
`endif

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic and handshake outputs.
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_req0_ready = 1'b0;
        w_req1_ready = 1'b0;
        w_rsp0_valid = 1'b0;
        w_rsp1_valid = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any_valid) begin
                    w_accept     = 1'b1;
                    w_req0_ready = ~w_gnt_id;
                    w_req1_ready = w_gnt_id;
                    w_next_state = EXEC;
                end
            end
            EXEC: begin
                w_next_state = RESP;
            end
            RESP: begin
                w_rsp0_valid = ~r_gnt;
                w_rsp1_valid = r_gnt;
                // Only the owner's ready can retire the response.
                if (r_gnt ? bus.rsp1_ready_i : bus.rsp0_ready_i) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Capture the granted operation on acceptance and latch the ALU result during EXEC.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_gnt    <= 1'b0;
            r_op     <= 4'd0;
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
        end else begin
            if (w_accept) begin
                r_gnt <= w_gnt_id;
                r_op  <= w_gnt_id ? bus.req1_op_i : bus.req0_op_i;
                r_a   <= w_gnt_id ? bus.req1_a_i  : bus.req0_a_i;
                r_b   <= w_gnt_id ? bus.req1_b_i  : bus.req0_b_i;
            end
            if (r_state == EXEC) begin
                r_result <= bus.alu_result_i;
            end
        end
    end

    // The ALU operands come straight from the capture registers.
    // This means they hold their last values outside EXEC.
    assign bus.alu_operation_o = r_op;
    assign bus.alu_a_o         = r_a;
    assign bus.alu_b_o         = r_b;

    assign bus.req0_ready_o    = w_req0_ready;
    assign bus.req1_ready_o    = w_req1_ready;
    assign bus.rsp0_valid_o    = w_rsp0_valid;
    assign bus.rsp1_valid_o    = w_rsp1_valid;
    assign bus.rsp_data_o      = r_result;

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_arbiter
//  Description : Self-checking bench for alu_arbiter. It contains:
//                - a directed vector table,
//                - hand-written multi-cycle sequences,
//                - a randomized run compared against a transaction-level
//                  reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;

`ifdef ALU_ARBITER_FIXED_PRIO_EN
    localparam bit c_FIXED = 1'b1;
`else
    localparam bit c_FIXED = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    alu_arbiter_if #(.DATA_WIDTH(32)) bus ();

    alu_arbiter #(.DATA_WIDTH(32)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model of the shared ALU.
    function automatic logic [31:0] alu_fn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return a << b[4:0];
            4'd6:    return a >> b[4:0];
            4'd7:    return ~(a | b);
            default: return a;
        endcase
    endfunction

    assign bus.alu_result_i = alu_fn(bus.alu_operation_o, bus.alu_a_o, bus.alu_b_o);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input bit v0, input logic [3:0] op0, input logic [31:0] a0, input logic [31:0] b0,
                         input bit v1, input logic [3:0] op1, input logic [31:0] a1, input logic [31:0] b1,
                         input bit rr0, input bit rr1);
        bus.req0_valid_i = v0;  bus.req0_op_i = op0; bus.req0_a_i = a0; bus.req0_b_i = b0;
        bus.req1_valid_i = v1;  bus.req1_op_i = op1; bus.req1_a_i = a1; bus.req1_b_i = b1;
        bus.rsp0_ready_i = rr0; bus.rsp1_ready_i = rr1;
    endtask

    task automatic idle_inputs();
        drive(0, 4'd0, 0, 0, 0, 4'd0, 0, 0, 0, 0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_rdy0"}, 32'(bus.req0_ready_o), 0);
        chk({tag, "_rdy1"}, 32'(bus.req1_ready_o), 0);
        chk({tag, "_rv0"},  32'(bus.rsp0_valid_o), 0);
        chk({tag, "_rv1"},  32'(bus.rsp1_valid_o), 0);
        chk({tag, "_data"}, bus.rsp_data_o, 0);
        chk({tag, "_aluop"}, 32'(bus.alu_operation_o), 0);
        chk({tag, "_alua"}, bus.alu_a_o, 0);
        chk({tag, "_alub"}, bus.alu_b_o, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b0;
        #1;
        chk_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        bit          rst;
        bit          v0;
        logic [3:0]  op0;
        logic [31:0] a0, b0;
        bit          v1;
        logic [3:0]  op1;
        logic [31:0] a1, b1;
        bit          rr0, rr1;
        bit          er0, er1, ev0, ev1;
        logic [31:0] ed;
    } vec_t;

    function automatic vec_t mk(bit rst, bit v0, logic [3:0] op0, logic [31:0] a0, logic [31:0] b0,
                                bit v1, logic [3:0] op1, logic [31:0] a1, logic [31:0] b1,
                                bit rr0, bit rr1, bit er0, bit er1, bit ev0, bit ev1, logic [31:0] ed);
        vec_t v;
        v.rst = rst; v.v0 = v0; v.op0 = op0; v.a0 = a0; v.b0 = b0;
        v.v1 = v1; v.op1 = op1; v.a1 = a1; v.b1 = b1;
        v.rr0 = rr0; v.rr1 = rr1;
        v.er0 = er0; v.er1 = er1; v.ev0 = ev0; v.ev1 = ev1; v.ed = ed;
        return v;
    endfunction

    // Reference-model state for the random phase.
    int          m_age;      // 0 = free, 1 = cycle after acceptance, 2 = awaiting consume
    bit          m_owner;
    bit          m_last;
    logic [3:0]  m_op;
    logic [31:0] m_a, m_b, m_exp;

    initial begin
        vec_t        tbl[$];
        bit          g1;
        bit          pres[2];
        bit          acc[2];
        logic [3:0]  rop[2];
        logic [31:0] ra[2];
        logic [31:0] rb[2];
        bit          rr[2];

        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        idle_inputs();

        // ---------------- directed table ----------------
        g1 = !c_FIXED;   // owner of the second tie
        // Single ADD 5+3 from req0
        tbl.push_back(mk(1, 1,4'd0,5,3,        0,4'd0,0,0,          1,1, 1,0,0,0, 0));
        tbl.push_back(mk(0, 0,4'd0,0,0,        0,4'd0,0,0,          1,1, 0,0,0,0, 0));
        tbl.push_back(mk(0, 0,4'd0,0,0,        0,4'd0,0,0,          1,1, 0,0,1,0, 8));
        tbl.push_back(mk(0, 0,4'd0,0,0,        0,4'd0,0,0,          1,1, 0,0,0,0, 0));
        // Tie after reset: req0 SUB 10-4, req1 AND F0&3C, both held
        tbl.push_back(mk(1, 1,4'd1,10,4, 1,4'd2,32'hF0,32'h3C, 1,1, 1,0,0,0, 0));
        tbl.push_back(mk(0, 1,4'd1,10,4, 1,4'd2,32'hF0,32'h3C, 1,1, 0,0,0,0, 0));
        tbl.push_back(mk(0, 1,4'd1,10,4, 1,4'd2,32'hF0,32'h3C, 1,1, 0,0,1,0, 6));
        tbl.push_back(mk(0, 1,4'd1,10,4, 1,4'd2,32'hF0,32'h3C, 1,1, !g1,g1,0,0, 0));
        tbl.push_back(mk(0, 1,4'd1,10,4, 1,4'd2,32'hF0,32'h3C, 1,1, 0,0,0,0, 0));
        tbl.push_back(mk(0, 1,4'd1,10,4, 1,4'd2,32'hF0,32'h3C, 1,1, 0,0,!g1,g1, g1 ? 32'h30 : 32'd6));
        tbl.push_back(mk(0, 1,4'd1,10,4, 1,4'd2,32'hF0,32'h3C, 1,1, 1,0,0,0, 0));
        tbl.push_back(mk(0, 1,4'd1,10,4, 1,4'd2,32'hF0,32'h3C, 1,1, 0,0,0,0, 0));
        tbl.push_back(mk(0, 1,4'd1,10,4, 1,4'd2,32'hF0,32'h3C, 1,1, 0,0,1,0, 6));

        foreach (tbl[i]) begin
            if (tbl[i].rst) do_reset();
            @(negedge clk);
            drive(tbl[i].v0, tbl[i].op0, tbl[i].a0, tbl[i].b0,
                  tbl[i].v1, tbl[i].op1, tbl[i].a1, tbl[i].b1, tbl[i].rr0, tbl[i].rr1);
            #1;
            chk($sformatf("tbl%0d_rdy0", i), 32'(bus.req0_ready_o), 32'(tbl[i].er0));
            chk($sformatf("tbl%0d_rdy1", i), 32'(bus.req1_ready_o), 32'(tbl[i].er1));
            chk($sformatf("tbl%0d_rv0", i),  32'(bus.rsp0_valid_o), 32'(tbl[i].ev0));
            chk($sformatf("tbl%0d_rv1", i),  32'(bus.rsp1_valid_o), 32'(tbl[i].ev1));
            if (tbl[i].ev0 || tbl[i].ev1)
                chk($sformatf("tbl%0d_data", i), bus.rsp_data_o, tbl[i].ed);
        end

        // ---------------- backpressure + cross-response isolation ----------------
        do_reset();
        @(negedge clk);
        drive(0,4'd0,7,7, 1,4'd0,1,1, 0,0);
        #1; chk("bp_accept1", 32'(bus.req1_ready_o), 1);
        @(negedge clk);
        drive(1,4'd0,7,7, 0,4'd0,0,0, 0,0);
        #1; chk("bp_exec_rdy0", 32'(bus.req0_ready_o), 0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            drive(1,4'd0,7,7, 0,4'd0,0,0, (k == 2), 0);   // stray rsp0_ready pulse
            #1;
            chk($sformatf("bp%0d_rv1", k),  32'(bus.rsp1_valid_o), 1);
            chk($sformatf("bp%0d_rv0", k),  32'(bus.rsp0_valid_o), 0);
            chk($sformatf("bp%0d_data", k), bus.rsp_data_o, 2);
            chk($sformatf("bp%0d_rdy0", k), 32'(bus.req0_ready_o), 0);
        end
        @(negedge clk);
        drive(1,4'd0,7,7, 0,4'd0,0,0, 0,1);
        #1;
        chk("bp_release_rv1", 32'(bus.rsp1_valid_o), 1);
        chk("bp_release_rdy0", 32'(bus.req0_ready_o), 0);
        @(negedge clk);
        #1;
        chk("bp_next_rdy0", 32'(bus.req0_ready_o), 1);
        chk("bp_next_rv1", 32'(bus.rsp1_valid_o), 0);

        // ---------------- reset while in RESP ----------------
        @(negedge clk);
        drive(0,4'd0,0,0, 0,4'd0,0,0, 0,0);
        @(negedge clk);
        #1;
        chk("rr_rv0", 32'(bus.rsp0_valid_o), 1);
        chk("rr_data", bus.rsp_data_o, 14);
        rst_n = 1'b0;
        #1;
        chk_zero("rr_async");
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            drive(0,4'd0,0,0, 0,4'd0,0,0, 1,1);
            #1;
            chk($sformatf("rr_after%0d_rv0", k), 32'(bus.rsp0_valid_o), 0);
            chk($sformatf("rr_after%0d_rv1", k), 32'(bus.rsp1_valid_o), 0);
        end

        // ---------------- four back-to-back ties ----------------
        do_reset();
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            drive(1,4'd3,32'h11,32'h22, 1,4'd4,32'h33,32'h44, 1,1);
            #1;
            if (c % 3 == 0) begin
                chk($sformatf("tie%0d_rdy0", c / 3), 32'(bus.req0_ready_o), 32'(c_FIXED || ((c / 3) % 2 == 0)));
                chk($sformatf("tie%0d_rdy1", c / 3), 32'(bus.req1_ready_o), 32'(!c_FIXED && ((c / 3) % 2 == 1)));
            end else begin
                chk($sformatf("tie_c%0d_rdy1", c), 32'(bus.req1_ready_o), 0);
            end
        end

        // ---------------- randomized run against reference model ----------------
        do_reset();
        m_age = 0; m_last = 1'b1; m_owner = 1'b0;
        m_op = '0; m_a = '0; m_b = '0; m_exp = '0;
        for (int i = 0; i < 2; i++) begin
            pres[i] = 0; acc[i] = 0; rop[i] = '0; ra[i] = '0; rb[i] = '0; rr[i] = 0;
        end
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            if ($urandom_range(99) == 0) begin
                rst_n = 1'b0;
                #1;
                chk("rnd_rst_rv0", 32'(bus.rsp0_valid_o), 0);
                chk("rnd_rst_rv1", 32'(bus.rsp1_valid_o), 0);
                rst_n = 1'b1;
                m_age = 0; m_last = 1'b1; acc[0] = 0; acc[1] = 0;
            end
            for (int i = 0; i < 2; i++) begin
                if (!pres[i] || acc[i]) begin
                    pres[i] = ($urandom_range(2) != 0);
                    rop[i]  = 4'($urandom_range(15));
                    ra[i]   = $urandom;
                    rb[i]   = $urandom;
                end else if ($urandom_range(9) == 0) begin
                    pres[i] = 0;
                end
                rr[i] = ($urandom_range(1) == 1);
                acc[i] = 0;
            end
            drive(pres[0], rop[0], ra[0], rb[0], pres[1], rop[1], ra[1], rb[1], rr[0], rr[1]);
            #1;
            if (m_age == 0) begin
                bit any;
                bit g;
                any = pres[0] || pres[1];
                if (pres[0] && pres[1]) g = c_FIXED ? 1'b0 : !m_last;
                else                    g = !pres[0];
                chk("rnd_rdy0", 32'(bus.req0_ready_o), 32'(any && !g));
                chk("rnd_rdy1", 32'(bus.req1_ready_o), 32'(any && g));
                chk("rnd_idle_rv0", 32'(bus.rsp0_valid_o), 0);
                chk("rnd_idle_rv1", 32'(bus.rsp1_valid_o), 0);
                if (any) begin
                    acc[g]  = 1;
                    m_owner = g;
                    m_op    = rop[g];
                    m_a     = ra[g];
                    m_b     = rb[g];
                    m_exp   = alu_fn(rop[g], ra[g], rb[g]);
                    if (!c_FIXED) m_last = g;
                    m_age   = 1;
                end
            end else if (m_age == 1) begin
                chk("rnd_exec_rdy0", 32'(bus.req0_ready_o), 0);
                chk("rnd_exec_rdy1", 32'(bus.req1_ready_o), 0);
                chk("rnd_exec_rv0", 32'(bus.rsp0_valid_o), 0);
                chk("rnd_exec_rv1", 32'(bus.rsp1_valid_o), 0);
                chk("rnd_alu_op", 32'(bus.alu_operation_o), 32'(m_op));
                chk("rnd_alu_a", bus.alu_a_o, m_a);
                chk("rnd_alu_b", bus.alu_b_o, m_b);
                m_age = 2;
            end else begin
                chk("rnd_resp_rdy0", 32'(bus.req0_ready_o), 0);
                chk("rnd_resp_rdy1", 32'(bus.req1_ready_o), 0);
                chk("rnd_resp_rv0", 32'(bus.rsp0_valid_o), 32'(!m_owner));
                chk("rnd_resp_rv1", 32'(bus.rsp1_valid_o), 32'(m_owner));
                chk("rnd_resp_data", bus.rsp_data_o, m_exp);
                if (rr[m_owner]) m_age = 0;
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
